control_merge: RTL

//  Nondeterministic merge of SIZE handshake channels that also reports which input won.

---
 rtl/control_merge_pkg.sv | 19 +
 rtl/control_merge_tehb.sv | 44 ++++
 rtl/control_merge.sv | 111 +++++++++++
 3 files changed

// File: rtl/control_merge_pkg.sv
// control_merge_pkg: helpers shared by the handshake merge and mux blocks.
//   clog2_min1      : index width needed to address n channels (never below 1)
//   index_width_ok  : legality check for an index port width
package control_merge_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic bit index_width_ok(input int size, input int iw);
        return iw >= clog2_min1(size);
    endfunction

endpackage

// File: rtl/control_merge_tehb.sv
// control_merge_tehb: one-slot transparent elastic buffer.
//   When empty the input passes straight through (zero latency); when the
//   consumer stalls, the offered word is captured and held until it drains.
//   clk, rst        : clock, synchronous active-high reset
//   ins_i/_valid_i  : upstream word and valid;  ins_ready_o = slot empty
//   outs_o/_valid_o : downstream word and valid; outs_ready_i from consumer
module control_merge_tehb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins_i,
    input  logic                  ins_valid_i,
    output logic                  ins_ready_o,
    output logic [DATA_WIDTH-1:0] outs_o,
    output logic                  outs_valid_o,
    input  logic                  outs_ready_i
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign ins_ready_o  = ~full_q;
    assign outs_valid_o = full_q | ins_valid_i;
    assign outs_o       = full_q ? data_q : ins_i;

    always_comb begin
        full_d = outs_valid_o & ~outs_ready_i;
        data_d = data_q;
        // Only capture into an empty slot; a held word is never replaced.
        if (!full_q && ins_valid_i && !outs_ready_i) data_d = ins_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/control_merge.sv
// control_merge: nondeterministic merge of SIZE handshake channels that also
// reports the winning channel number, feeding a downstream handshake mux.
//   Path: priority arbiter -> one-slot TEHB (data+index) -> eager fork.
//   clk, rst                    : clock, synchronous active-high reset
//   ins/ins_valid/ins_ready     : SIZE packed input channels
//   outs/outs_valid/outs_ready  : merged data channel
//   index/index_valid/index_ready : winning channel number
module control_merge
    import control_merge_pkg::*;
#(
    parameter int SIZE        = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SIZE*DATA_WIDTH-1:0] ins,
    input  logic [SIZE-1:0]            ins_valid,
    output logic [SIZE-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]      outs,
    output logic                       outs_valid,
    input  logic                       outs_ready,
    output logic [INDEX_WIDTH-1:0]     index,
    output logic                       index_valid,
    input  logic                       index_ready
);

    localparam int PAYLOAD_WIDTH = DATA_WIDTH + INDEX_WIDTH;

    if (!index_width_ok(SIZE, INDEX_WIDTH)) begin : g_bad_index_width
        $error("control_merge: INDEX_WIDTH too small for SIZE");
    end

    // ---------------- priority arbiter ----------------
    logic [SIZE-1:0]          win_oh;
    logic [INDEX_WIDTH-1:0]   win_idx;
    logic [DATA_WIDTH-1:0]    win_data;
    logic                     any_valid;
    logic                     tehb_ready;

    // Descending scan so the lowest valid channel is the last to overwrite.
    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        win_data = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (ins_valid[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = INDEX_WIDTH'(i);
                win_data  = ins[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign any_valid = |ins_valid;
    assign ins_ready = win_oh & {SIZE{tehb_ready}};

    // ---------------- one-slot buffer ----------------
    logic [PAYLOAD_WIDTH-1:0] tehb_data;
    logic                     tehb_valid;
    logic                     fork_ready;

    control_merge_tehb #(
        .DATA_WIDTH (PAYLOAD_WIDTH)
    ) u_tehb (
        .clk          (clk),
        .rst          (rst),
        .ins_i        ({win_idx, win_data}),
        .ins_valid_i  (any_valid),
        .ins_ready_o  (tehb_ready),
        .outs_o       (tehb_data),
        .outs_valid_o (tehb_valid),
        .outs_ready_i (fork_ready)
    );

    // ---------------- eager fork ----------------
    // sent_*_q remember that a consumer already took the current token so a
    // fast consumer is not offered it twice while the other one lags.
    logic sent_o_q, sent_o_d;
    logic sent_i_q, sent_i_d;

    assign outs        = tehb_data[DATA_WIDTH-1:0];
    assign index       = tehb_data[PAYLOAD_WIDTH-1:DATA_WIDTH];
    assign outs_valid  = tehb_valid & ~sent_o_q;
    assign index_valid = tehb_valid & ~sent_i_q;
    assign fork_ready  = (outs_ready | sent_o_q) & (index_ready | sent_i_q);

    always_comb begin
        sent_o_d = sent_o_q;
        sent_i_d = sent_i_q;
        if (fork_ready) begin
            sent_o_d = 1'b0;
            sent_i_d = 1'b0;
        end else begin
            sent_o_d = sent_o_q | (outs_valid & outs_ready);
            sent_i_d = sent_i_q | (index_valid & index_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_o_q <= 1'b0;
            sent_i_q <= 1'b0;
        end else begin
            sent_o_q <= sent_o_d;
            sent_i_q <= sent_i_d;
        end
    end

endmodule
